decode_stage_pipelined: RTL and testbench

- Registered Decode-stage front end with valid/ready handshake on both sides.
- Accepts a fetched instruction plus PC, splits the instruction into its RV32 fields, classifies the format, builds the sign-extended immediate and flags illegal encodings.
- Presents the result to Execute one cycle later through a two-entry skid buffer, so throughput stays at one instruction per cycle while the in_ready path stays registered.
- Sits between Fetch and the control unit / register file read.

---
 rtl/decode_stage_pipelined.sv | 153 +++++++++++++++
 tb/tb_decode_stage_pipelined.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipelined.sv
// Registered RV32 decode stage: splits fields, classifies format, builds the
// sign-extended immediate and presents results through a two-entry skid buffer.
module decode_stage_pipelined #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instruction,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [6:0]          out_opcode,
  output logic [4:0]          out_rd,
  output logic [2:0]          out_funct3,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [6:0]          out_funct7,
  output logic [XLEN-1:0]     out_imm,
  output logic [2:0]          out_fmt,
  output logic                out_illegal,
  output logic [PC_WIDTH-1:0] out_pc
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    logic [XLEN-1:0]     imm;
    logic [2:0]          fmt;
    logic                illegal;
  } entry_t;

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t dec;
  fmt_e   fmt;
  logic [31:0] imm32;
  logic   accept, consume;

  // Input-side decode
  always_comb begin
    fmt   = FMT_ILL;
    imm32 = '0;
    if (in_instruction[1:0] == 2'b11) begin
      unique case (in_instruction[6:0])
        7'b0110011:                                 fmt = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = FMT_I;
        7'b0100011:                                 fmt = FMT_S;
        7'b1100011:                                 fmt = FMT_B;
        7'b0110111, 7'b0010111:                     fmt = FMT_U;
        7'b1101111:                                 fmt = FMT_J;
        default:                                    fmt = FMT_ILL;
      endcase
    end
    unique case (fmt)
      FMT_I: imm32 = {{20{in_instruction[31]}}, in_instruction[31:20]};
      FMT_S: imm32 = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
      FMT_B: imm32 = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                      in_instruction[30:25], in_instruction[11:8], 1'b0};
      FMT_U: imm32 = {in_instruction[31:12], 12'b0};
      FMT_J: imm32 = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                      in_instruction[20], in_instruction[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec.instr   = in_instruction;
    dec.pc      = in_pc;
    dec.imm     = XLEN'($signed(imm32));
    dec.fmt     = fmt;
    dec.illegal = (fmt == FMT_ILL);
  end

  assign accept  = in_valid & in_ready_q;
  assign consume = (state_q != ST_EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (accept) begin
          state_d = ST_ONE;
          main_d  = dec;
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = dec;
          end else if (accept) begin
            state_d = ST_TWO;
            skid_d  = dec;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: if (consume) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Payload registers carry no reset; outputs are masked while EMPTY instead.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_opcode  = out_valid ? main_q.instr[6:0]   : '0;
  assign out_rd      = out_valid ? main_q.instr[11:7]  : '0;
  assign out_funct3  = out_valid ? main_q.instr[14:12] : '0;
  assign out_rs1     = out_valid ? main_q.instr[19:15] : '0;
  assign out_rs2     = out_valid ? main_q.instr[24:20] : '0;
  assign out_funct7  = out_valid ? main_q.instr[31:25] : '0;
  assign out_imm     = out_valid ? main_q.imm          : '0;
  assign out_fmt     = out_valid ? main_q.fmt          : '0;
  assign out_illegal = out_valid ? main_q.illegal      : 1'b0;
  assign out_pc      = out_valid ? main_q.pc           : '0;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Self-checking bench for decode_stage_pipelined: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_decode_stage_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instruction, in_pc;

  logic        in_ready, out_valid, out_illegal;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt;
  logic [31:0] out_imm, out_pc;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [6:0]  out_opcode64, out_funct764;
  logic [4:0]  out_rd64, out_rs164, out_rs264;
  logic [2:0]  out_funct364, out_fmt64;
  logic [63:0] out_imm64;
  logic [31:0] out_pc64;

  decode_stage_pipelined #(.XLEN(32), .PC_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct7(out_funct7), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_pc(out_pc)
  );

  decode_stage_pipelined #(.XLEN(64), .PC_WIDTH(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instruction(in_instruction), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_opcode(out_opcode64), .out_rd(out_rd64), .out_funct3(out_funct364), .out_rs1(out_rs164),
    .out_rs2(out_rs264), .out_funct7(out_funct764), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64), .out_pc(out_pc64)
  );

  wire logic [101:0] dut_b = {out_valid, in_ready, out_opcode, out_rd, out_funct3, out_rs1,
                              out_rs2, out_funct7, out_imm, out_fmt, out_illegal, out_pc};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  bit   rdy_live;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [2:0] ref_fmt(input logic [31:0] w);
    if (w[1:0] != 2'b11) return 3'd7;
    case (w[6:0])
      7'h33:                     return 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
      7'h23:                     return 3'd2;
      7'h63:                     return 3'd3;
      7'h37, 7'h17:              return 3'd4;
      7'h6F:                     return 3'd5;
      default:                   return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w, input logic [2:0] f);
    int s;
    s = w;
    case (f)
      3'd1: return s >>> 20;
      3'd2: return (s >>> 25) * 32 + int'(w[11:7]);
      3'd3: return (s >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      3'd4: return w & 32'hFFFF_F000;
      3'd5: return (s >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [101:0] exp_bundle();
    logic [31:0] ins, imm;
    logic [2:0]  f;
    if (q.size() == 0) return {1'b0, rdy_live, 100'd0};
    ins = q[0].instr;
    f   = ref_fmt(ins);
    imm = ref_imm(ins, f);
    return {1'b1, rdy_live && (q.size() < 2), ins[6:0], ins[11:7], ins[14:12], ins[19:15],
            ins[24:20], ins[31:25], imm, f, (f == 3'd7), q[0].pc};
  endfunction

  // One clock of stimulus; the model advances at the edge, outputs settle by return.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic r, input logic fl);
    bit acc, con;
    @(negedge clk);
    in_valid = v; in_instruction = ins; in_pc = pc; out_ready = r; flush = fl;
    acc = v && rdy_live && (q.size() < 2);
    con = (q.size() > 0) && r;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back('{ins, pc});
    end
    rdy_live = !reset;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instruction = '0; in_pc = '0; rdy_live = 1'b0;
    #12;
    checks++;
    if (dut_b !== exp_bundle()) begin
      errors++; $display("FAIL reset_hold got=%h exp=%h", dut_b, exp_bundle());
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (dut_b !== exp_bundle()) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", dut_b, exp_bundle());
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b1 || dut_b !== exp_bundle()) begin
      errors++; $display("FAIL reset_first_edge got=%h exp=%h", dut_b, exp_bundle());
    end
  endtask

  task automatic test_addi();
    step(1'b1, 32'hFFF30293, 32'h100, 1'b1, 1'b0);
    checks++;
    if (dut_b !== exp_bundle()) begin
      errors++; $display("FAIL addi_bundle got=%h exp=%h", dut_b, exp_bundle());
    end
    checks++;
    if (out_imm !== 32'hFFFFFFFF || out_fmt !== 3'd1 || out_rd !== 5'd5 || out_rs1 !== 5'd6 ||
        out_opcode !== 7'h13 || out_pc !== 32'h100 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL addi_fields imm=%h fmt=%0d rd=%0d rs1=%0d pc=%h exp imm=ffffffff fmt=1 rd=5 rs1=6 pc=100",
                         out_imm, out_fmt, out_rd, out_rs1, out_pc);
    end
    checks++;
    if (out_imm64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL addi_imm64 got=%h exp=ffffffffffffffff", out_imm64);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (dut_b !== exp_bundle()) begin
      errors++; $display("FAIL addi_drain got=%h exp=%h", dut_b, exp_bundle());
    end
  endtask

  task automatic test_stream();
    logic [31:0] prog [5];
    prog = '{32'hFE20AE23, 32'h00208463, 32'h123452B7, 32'h001000EF, 32'h002081B3};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, prog[i], 32'h200 + 32'(i * 4), 1'b1, 1'b0);
      checks++;
      if (dut_b !== exp_bundle() || out_pc !== 32'h200 + 32'(i * 4)) begin
        errors++; $display("FAIL stream_%0d got=%h exp=%h", i, dut_b, exp_bundle());
      end
      if (i == 0) begin
        checks++;
        if (out_imm !== 32'hFFFFFFFC || out_fmt !== 3'd2) begin
          errors++; $display("FAIL stream_sw imm=%h fmt=%0d exp imm=fffffffc fmt=2", out_imm, out_fmt);
        end
      end
      if (i == 3) begin
        checks++;
        if (out_imm !== 32'h00000800 || out_fmt !== 3'd5) begin
          errors++; $display("FAIL stream_jal imm=%h fmt=%0d exp imm=00000800 fmt=5", out_imm, out_fmt);
        end
      end
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    logic [31:0] ins [3];
    ins = '{32'h00100093, 32'h00200113, 32'h00300193};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ins[i], 32'h300 + 32'(i * 4), 1'b0, 1'b0);
      checks++;
      if (dut_b !== exp_bundle() || out_pc !== 32'h300 || in_ready !== (i == 0)) begin
        errors++; $display("FAIL stall_%0d got=%h exp=%h", i, dut_b, exp_bundle());
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (dut_b !== exp_bundle() || (i == 0 && out_pc !== 32'h304) || (i == 1 && out_valid !== 1'b0)) begin
        errors++; $display("FAIL stall_release_%0d got=%h exp=%h", i, dut_b, exp_bundle());
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] w [2];
    w = '{32'h00000000, 32'h0000007F};
    for (int i = 0; i < 2; i++) begin
      step(1'b1, w[i], 32'h400, 1'b1, 1'b0);
      checks++;
      if (dut_b !== exp_bundle() || out_illegal !== 1'b1 || out_fmt !== 3'd7 || out_imm !== '0 ||
          out_opcode !== w[i][6:0]) begin
        errors++; $display("FAIL illegal_%0d got=%h exp=%h", i, dut_b, exp_bundle());
      end
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    step(1'b1, 32'h00100093, 32'h500, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 32'h504, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 32'h508, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_b !== exp_bundle()) begin
      errors++; $display("FAIL flush_two got=%h exp=%h", dut_b, exp_bundle());
    end
    step(1'b1, 32'h00400213, 32'h510, 1'b0, 1'b0);
    step(1'b1, 32'h00500293, 32'h514, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_b !== exp_bundle()) begin
      errors++; $display("FAIL flush_one got=%h exp=%h", dut_b, exp_bundle());
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || dut_b !== exp_bundle()) begin
      errors++; $display("FAIL flush_no_ghost got=%h exp=%h", dut_b, exp_bundle());
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [10];
    logic [31:0] w;
    int          bad;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      w = $urandom();
      if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 9)];
      step(1'($urandom_range(0, 3) != 0), w, $urandom(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
      checks++;
      if (dut_b !== exp_bundle()) begin
        errors++;
        if (bad < 5) $display("FAIL random_%0d got=%h exp=%h", i, dut_b, exp_bundle());
        bad++;
      end
    end
    step(1'b0, '0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'hFFF30293, 32'h600, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    q.delete(); rdy_live = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || dut_b !== exp_bundle()) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", dut_b, exp_bundle());
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset_hold in_ready=%b out_valid=%b exp 0 0", in_ready, out_valid);
    end
    @(negedge clk); reset = 1'b0;
    step(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b1 || dut_b !== exp_bundle()) begin
      errors++; $display("FAIL async_reset_release got=%h exp=%h", dut_b, exp_bundle());
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_stream();
    test_stall();
    test_illegal();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
